lane_array_fifo: RTL and testbench
==================================

Name: lane_array_fifo

Overview:
- Parametrised N-lane buffer carrying packed-array words, each [N-1:0][W-1:0], between a producer and a consumer over a valid/ready handshake.
- Generalises the fixed 4x28 packed-array port to arbitrary lane count, lane width and buffer depth.
- Adds a per-lane enable mask, occupancy reporting and a synchronous flush.
- Sits between lane-array producer and consumer instances wherever back-pressure must be absorbed.

Parameters:
- N, 4, number of lanes; N >= 1.
- W, 28, bits per lane.
- DEPTH, 4, number of entries; power of two, DEPTH >= 2.
- CW, $clog2(DEPTH+1), occupancy counter width; derived, not overridden.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all entries.
- in_valid  in  1  producer has a word.
- in_ready  out  1  buffer can accept.
- in_data  in  [N-1:0][W-1:0]  producer word.
- in_lane_en  in  N  per-lane valid mask.
- out_valid  out  1  buffer has a word.
- out_ready  in  1  consumer accepts.
- out_data  out  [N-1:0][W-1:0]  head word.
- out_lane_en  out  N  head mask.
- count  out  CW  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wr_ptr, rd_ptr and count go to 0; out_valid=0, in_ready=1.
  - out_data is all zeros and out_lane_en=0.
  - Storage contents are not reset.
- Push: in_valid && in_ready at an edge writes entry[wr_ptr]; wr_ptr+1 mod DEPTH.
  - Lanes with in_lane_en[i]=0 are stored as W'0, so out_data lane i=0 for those lanes.
- Pop: out_valid && out_ready at an edge advances rd_ptr+1 mod DEPTH.
- Outputs out_data and out_lane_en are driven from entry[rd_ptr]. They read zero whenever out_valid=0.
- in_ready = (count != DEPTH); out_valid = (count != 0). Both are combinational from registered count only; there is no combinational path from in_* to out_* or from out_ready to in_ready.
- Latency: a word pushed into an empty buffer appears at the output one cycle after the push edge (without the optional feature).
- Simultaneous push and pop when 0 < count < DEPTH: count unchanged, both pointers advance.
- Full (count=DEPTH): in_ready=0 and pushes are ignored, even if a pop occurs the same cycle; the producer retries next cycle.
- Empty: out_valid=0; out_ready is ignored.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. Occupancy is held in count, not derived from the pointers.
- Flush:
  - At the edge: pointers and count go to 0.
  - A push or pop in the same cycle is discarded.
  - flush has priority over everything except rst_n.
- Reset mid-transfer: all in-flight words are lost; the next cycle sees the reset state.
- Invalid parameters (DEPTH not a power of two, N<1, W<1) fail at elaboration via an assertion.

Optional Feature:
- Macro: LANE_ARRAY_FIFO_BYPASS_EN.
- With the macro defined: when count=0, in_valid=1 and out_ready=1, the word passes combinationally.
  - out_valid=1, out_data=masked in_data, out_lane_en=in_lane_en in the same cycle.
  - Nothing is written; count stays 0.
  - If out_ready=0, the word is stored normally.
- Without the macro: no bypass; minimum latency is 1 cycle.

Decomposition:
- Package lane_array_pkg:
  - LANE_N_DEFAULT=4, LANE_W_DEFAULT=28.
  - typedef lane_word_t logic [LANE_W_DEFAULT-1:0].
  - typedef lane_arr_t lane_word_t [LANE_N_DEFAULT-1:0], packed.
  - Mask-apply function lane_mask(arr, en) returning a zeroed-lane copy.
- Sub-module lane_array_fifo_mem:
  - DEPTH x (N*W + N) register array.
  - One write port, one asynchronous read port.
  - No reset.
- The top module holds pointers, count, flush, handshake and bypass logic.

Test Plan:
1. Reset then idle: rst_n low 3 cycles, release -> count=0, in_valid... in_ready=1, out_valid=0, out_data=0.
2. Fill and drain, N=4, W=28, DEPTH=4:
   - Push 0x0000001, 0x0000002, 0x0000003, 0x0000004 on all lanes with out_ready=0 -> count=4, in_ready=0.
   - A fifth push is ignored.
   - Drain -> words return in order 1..4, count steps 4,3,2,1,0.
3. Lane mask: push in_data lanes {0xAAAAAAA,0xBBBBBBB,0xCCCCCCC,0xDDDDDDD} with in_lane_en=4'b0101 -> out_data={0,0xBBBBBBB,0,0xDDDDDDD}, out_lane_en=4'b0101.
4. Simultaneous push/pop at count=2 for 10 cycles -> count stays 2, pointers wrap, output order is preserved with no loss or duplication.
5. Flush with count=3 while pushing -> next cycle count=0, out_valid=0; the pushed word is absent.
   - Asynchronous reset asserted mid-drain gives the same result.
6. Bypass:
   - With LANE_ARRAY_FIFO_BYPASS_EN, empty buffer, in_valid=out_ready=1, data 0x1234567 -> out_valid=1 and out_data=0x1234567 the same cycle, count=0.
   - Without the macro -> the word appears the next cycle with count=1.

Source files
------------

// File: rtl/lane_array_pkg.sv
// lane_array_pkg: shared lane-array types and helpers for the lane-array blocks.
// Default geometry is 4 lanes of 28 bits.
package lane_array_pkg;

    localparam int LANE_N_DEFAULT = 4;
    localparam int LANE_W_DEFAULT = 28;

    typedef logic [LANE_W_DEFAULT-1:0] lane_word_t;
    typedef lane_word_t [LANE_N_DEFAULT-1:0] lane_arr_t;

    // Return a copy of arr with every lane whose enable bit is clear forced to zero.
    function automatic lane_arr_t lane_mask(input lane_arr_t arr,
                                            input logic [LANE_N_DEFAULT-1:0] en);
        lane_arr_t res;
        for (int i = 0; i < LANE_N_DEFAULT; i++) begin
            res[i] = en[i] ? arr[i] : '0;
        end
        return res;
    endfunction

endpackage

// File: rtl/lane_array_fifo_mem.sv
// lane_array_fifo_mem: DEPTH x EW register array, one synchronous write port and
// one asynchronous read port.
module lane_array_fifo_mem #(
    parameter int DEPTH = 4,
    parameter int EW    = 116
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [EW-1:0]            wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [EW-1:0]            rd_data
);

    logic [EW-1:0] mem [DEPTH];

    // Capture the write word at the addressed entry.
    // NOTE: storage is deliberately not reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lane_array_fifo.sv
// lane_array_fifo: N-lane packed-array FIFO with valid/ready handshake, per-lane
// enable mask, occupancy count and synchronous flush.
// Optional feature macro: LANE_ARRAY_FIFO_BYPASS_EN (zero-latency pass-through when empty).
module lane_array_fifo
    import lane_array_pkg::*;
#(
    parameter int  N     = LANE_N_DEFAULT,
    parameter int  W     = LANE_W_DEFAULT,
    parameter int  DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N-1:0][W-1:0] in_data,
    input  logic [N-1:0]        in_lane_en,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N-1:0][W-1:0] out_data,
    output logic [N-1:0]        out_lane_en,
    output logic [CW-1:0]       count
);

    localparam int            AW   = $clog2(DEPTH);
    localparam int            EW   = N * W + N;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || N < 1 || W < 1) begin : g_bad_params
        $error("lane_array_fifo: DEPTH must be a power of two >= 2, N and W must be >= 1");
    end

    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [N-1:0][W-1:0]  masked_in;
    logic [N-1:0][W-1:0]  mem_data;
    logic [N-1:0]         mem_lane_en;
    logic [EW-1:0]        rd_word;
    logic                 not_empty;
    logic                 bypass;
    logic                 do_push;
    logic                 do_pop;

    // Disabled lanes are stored as zero so the consumer never sees stale lane data.
    if (N == LANE_N_DEFAULT && W == LANE_W_DEFAULT) begin : g_mask_pkg
        assign masked_in = lane_mask(in_data, in_lane_en);
    end else begin : g_mask_generic
        // Zero each disabled lane of the incoming word.
        always_comb begin
            for (int i = 0; i < N; i++) begin
                masked_in[i] = in_lane_en[i] ? in_data[i] : '0;
            end
        end
    end

    assign not_empty = (count != '0);
    assign in_ready  = (count != FULL);

`ifdef LANE_ARRAY_FIFO_BYPASS_EN
    assign bypass = !not_empty && in_valid && out_ready;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed word is consumed directly, so it is neither written nor popped.
    assign do_push = in_valid && in_ready && !bypass && !flush;
    assign do_pop  = not_empty && out_ready && !flush;

    // Pointer and occupancy state; flush has priority over push and pop.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    lane_array_fifo_mem #(
        .DEPTH (DEPTH),
        .EW    (EW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (do_push),
        .wr_addr (wr_ptr),
        .wr_data ({in_lane_en, masked_in}),
        .rd_addr (rd_ptr),
        .rd_data (rd_word)
    );

    assign {mem_lane_en, mem_data} = rd_word;

    // Present the bypassed input, the head entry, or zeros when nothing is valid.
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        out_valid   = not_empty;
        out_data    = '0;
        out_lane_en = '0;
        if (bypass) begin
            out_valid   = 1'b1;
            out_data    = masked_in;
            out_lane_en = in_lane_en;
        end else if (not_empty) begin
            out_data    = mem_data;
            out_lane_en = mem_lane_en;
        end
    end

endmodule

// File: tb/tb_lane_array_fifo.sv
// tb_lane_array_fifo: directed stimulus with a scoreboard queue; a negedge monitor
// records accepted words and compares every word the DUT hands to the consumer.
module tb_lane_array_fifo;

    localparam int N     = 4;
    localparam int W     = 28;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic                clk = 1'b0;
    logic                rst_n;
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [N-1:0][W-1:0] in_data;
    logic [N-1:0]        in_lane_en;
    logic                out_valid;
    logic                out_ready;
    logic [N-1:0][W-1:0] out_data;
    logic [N-1:0]        out_lane_en;
    logic [CW-1:0]       count;

    logic [N*W-1:0]      pend_exp;
    logic [N*W+N-1:0]    sb[$];
    int                  checks   = 0;
    int                  failures = 0;

    lane_array_fifo #(
        .N     (N),
        .W     (W),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_lane_en  (in_lane_en),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_lane_en (out_lane_en),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N*W-1:0] d, input logic [N-1:0] en, input logic [N*W-1:0] exp);
        in_valid   = 1'b1;
        in_data    = d;
        in_lane_en = en;
        pend_exp   = exp;
    endtask

    // Scoreboard monitor: queue accepted words, then compare each consumed word.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            sb.delete();
        end else begin
            if (in_valid && in_ready) begin
                sb.push_back({in_lane_en, pend_exp});
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected: actual=%0h required=none", out_data);
                end else begin
                    logic [N*W+N-1:0] item;
                    item = sb.pop_front();
                    check("sb_data", 128'(out_data), 128'(item[N*W-1:0]));
                    check("sb_lane_en", 128'(out_lane_en), 128'(item[N*W+N-1:N*W]));
                end
            end
        end
    end

    initial begin
        logic [N*W-1:0] w;
        rst_n      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_lane_en = '0;
        out_ready  = 1'b0;
        pend_exp   = '0;

        // 1. Reset then idle
        repeat (3) @(posedge clk);
        #1;
        check("rst_count_low", 128'(count), 128'(0));
        check("rst_out_valid_low", 128'(out_valid), 128'(0));
        rst_n = 1'b1;
        step();
        check("idle_count", 128'(count), 128'(0));
        check("idle_in_ready", 128'(in_ready), 128'(1));
        check("idle_out_valid", 128'(out_valid), 128'(0));
        check("idle_out_data", 128'(out_data), 128'(0));
        check("idle_out_lane_en", 128'(out_lane_en), 128'(0));

        // 2. Fill to full, push while full, drain in order
        for (int k = 1; k <= 4; k++) begin
            w = {4{28'(k)}};
            drive(w, 4'hF, w);
            step();
            check("fill_count", 128'(count), 128'(k));
        end
        check("full_in_ready", 128'(in_ready), 128'(0));
        w = {4{28'h0000005}};
        drive(w, 4'hF, w);
        step();
        check("full_push_ignored", 128'(count), 128'(4));
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("full_pop_push_count", 128'(count), 128'(3));
        step();
        check("drain_count_2", 128'(count), 128'(2));
        step();
        check("drain_count_1", 128'(count), 128'(1));
        step();
        check("drain_count_0", 128'(count), 128'(0));
        check("drain_out_valid", 128'(out_valid), 128'(0));
        out_ready = 1'b0;

        // 3. Lane mask
        drive({28'hAAAAAAA, 28'hBBBBBBB, 28'hCCCCCCC, 28'hDDDDDDD}, 4'b0101,
              {28'h0000000, 28'hBBBBBBB, 28'h0000000, 28'hDDDDDDD});
        step();
        in_valid = 1'b0;
        check("mask_data", 128'(out_data), 128'({28'h0, 28'hBBBBBBB, 28'h0, 28'hDDDDDDD}));
        check("mask_lane_en", 128'(out_lane_en), 128'(4'b0101));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("mask_pop_count", 128'(count), 128'(0));

        // 4. Simultaneous push/pop at count=2 across pointer wrap
        for (int k = 0; k < 2; k++) begin
            w = {4{28'(16'h100 + k)}};
            drive(w, 4'hF, w);
            step();
        end
        check("pp_start_count", 128'(count), 128'(2));
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            w = {4{28'(16'h200 + k)}};
            drive(w, 4'hF, w);
            step();
            check("pp_count", 128'(count), 128'(2));
        end
        in_valid = 1'b0;
        step();
        step();
        out_ready = 1'b0;
        check("pp_end_count", 128'(count), 128'(0));
        check("pp_sb_empty", 128'(sb.size()), 128'(0));

        // 5a. Flush with count=3 while pushing
        for (int k = 0; k < 3; k++) begin
            w = {4{28'(16'h300 + k)}};
            drive(w, 4'hF, w);
            step();
        end
        check("flush_pre_count", 128'(count), 128'(3));
        w = {4{28'h00003FF}};
        drive(w, 4'hF, w);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_count", 128'(count), 128'(0));
        check("flush_out_valid", 128'(out_valid), 128'(0));
        check("flush_out_data", 128'(out_data), 128'(0));
        step();
        check("flush_word_absent", 128'(count), 128'(0));

        // 5b. Asynchronous reset mid-drain
        for (int k = 0; k < 3; k++) begin
            w = {4{28'(16'h400 + k)}};
            drive(w, 4'hF, w);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("mid_drain_count", 128'(count), 128'(2));
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_count", 128'(count), 128'(0));
        check("async_rst_out_valid", 128'(out_valid), 128'(0));
        check("async_rst_in_ready", 128'(in_ready), 128'(1));
        out_ready = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_count", 128'(count), 128'(0));
        check("post_rst_out_data", 128'(out_data), 128'(0));

        // 6. Latency from an empty buffer
        out_ready = 1'b1;
        w = {4{28'h1234567}};
        drive(w, 4'hF, w);
        #1;
`ifdef LANE_ARRAY_FIFO_BYPASS_EN
        check("byp_out_valid", 128'(out_valid), 128'(1));
        check("byp_out_data", 128'(out_data), 128'({4{28'h1234567}}));
        check("byp_count", 128'(count), 128'(0));
        step();
        in_valid = 1'b0;
        check("byp_count_after", 128'(count), 128'(0));
`else
        check("lat_out_valid_same", 128'(out_valid), 128'(0));
        step();
        in_valid = 1'b0;
        check("lat_out_valid_next", 128'(out_valid), 128'(1));
        check("lat_count_next", 128'(count), 128'(1));
        check("lat_out_data_next", 128'(out_data), 128'({4{28'h1234567}}));
        step();
        check("lat_count_drained", 128'(count), 128'(0));
`endif
        out_ready = 1'b0;
        step();
        check("final_sb_empty", 128'(sb.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
